tag_fifo: RTL and testbench
===========================

Name: tag_fifo

Overview:
- Free-list of renaming tags feeding the dispatch stage.
- Dispatch pops one tag per cycle and writes it into the register status table as dispatch_tag.
- The ROB returns one tag per cycle on commit, making it free again.
- Circular FIFO of NUM_TAGS entries, preloaded full at reset, with show-ahead head output.

Parameters:
- TAG_W, 6, tag width in bits.
- NUM_TAGS, 64 (2**TAG_W), FIFO depth and number of distinct tags.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- dispatch_tag_rd  input  1  pop request from dispatch; consumes the current head tag.
- tagfifo_tag  output  TAG_W  head tag, combinational from storage (show-ahead).
- tagfifo_valid  output  1  FIFO not empty; tagfifo_tag meaningful.
- tagfifo_full  output  1  all NUM_TAGS tags present.
- tagfifo_count  output  TAG_W+1  number of free tags, 0..NUM_TAGS.
- rob_commit_tag  input  TAG_W  tag being returned by the ROB.
- rob_commit_valid  input  1  push strobe for rob_commit_tag.
- tagfifo_err  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Storage: NUM_TAGS x TAG_W register array.
- Pointers: rd_ptr and wr_ptr, each TAG_W+1 bits; the MSB is the wrap bit.
- Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Reset (sync, 1 cycle):
  - mem[i] = i for all i.
  - rd_ptr = 0; wr_ptr = NUM_TAGS (wrap bit set).
  - Resulting outputs: tagfifo_full=1, tagfifo_valid=1, tagfifo_count=64, tagfifo_tag=0, tagfifo_err=0.
- Pop (dispatch_tag_rd=1 and not empty): rd_ptr++ at the clock edge. The next head appears the following cycle. A pop while empty is ignored and pointers are unchanged.
- Push (rob_commit_valid=1 and not full): mem[wr_ptr low] <= rob_commit_tag; wr_ptr++. A push while full is dropped.
- Simultaneous pop and push:
  - Neither full nor empty: both are performed; count unchanged.
  - Empty: push performed, pop ignored. There is no same-cycle bypass; the tag is visible next cycle.
  - Full: pop performed, push dropped, count goes 64 -> 63.
- Pointers wrap modulo 2*NUM_TAGS; addresses are the low TAG_W bits.
- tagfifo_count = wr_ptr - rd_ptr, computed in TAG_W+1 bits.
- All outputs are pure functions of registered state; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation overrides any pop or push in that cycle. The FIFO returns to the preloaded-full state, discarding in-flight bookkeeping.

Optional Feature:
- Macro: TAG_FIFO_CHECK_EN.
- When defined:
  - Keeps an NUM_TAGS-bit outstanding bitmap, cleared at reset.
  - The bit for tagfifo_tag is set on an accepted pop.
  - The bit for rob_commit_tag is cleared on an accepted push.
  - tagfifo_err sets next cycle and holds until reset on any of:
    - a push of a tag whose bit is 0 (double free);
    - a push while full;
    - a pop while empty.
  - Error events do not alter normal FIFO behaviour beyond the drop/ignore rules above.
- When undefined: no bitmap is built and tagfifo_err is tied to 0.

Decomposition:
- Shared package cobalt_pkg holds:
  - constants TAG_W = 6 and NUM_TAGS = 64;
  - typedef tag_t = logic [TAG_W-1:0];
  - typedef tag_cnt_t = logic [TAG_W:0].
- The RST and ROB reuse tag_t.
- Single module; no sub-module. The check logic is an ifdef block inside tag_fifo.

Test Plan:
- Reset 5 cycles -> tagfifo_count=64, tagfifo_full=1, tagfifo_tag=0, tagfifo_err=0.
- 64 consecutive pops -> tagfifo_tag sequence 0..63. Afterwards tagfifo_valid=0 and count=0. A 65th pop leaves count=0 and sets tagfifo_err (CHECK_EN).
- From empty, push tags 5, 9, 2 on 3 cycles -> count=3. Pops return 5, 9, 2 in order.
- Steady-state simultaneous pop and push for 200 cycles with half full -> count constant at 32. Pointers wrap without tag loss. Popped stream equals pushed stream delayed by 32.
- Push while full (tag 7 straight after reset) -> count stays 64, FIFO contents unchanged, tagfifo_err=1 (CHECK_EN) or 0 (no CHECK_EN).
- Pop 10 tags, then assert reset during a push of tag 3 -> after reset count=64 and the head tag is 0. Then pop 1, push tag 0, push tag 0 again -> tagfifo_err=1 on the second push (double free, CHECK_EN).

Source files
------------

// File: rtl/cobalt_pkg.sv
// rtl/cobalt_pkg.sv - shared renaming-tag constants and types
package cobalt_pkg;

  localparam int TAG_W    = 6;
  localparam int NUM_TAGS = 2 ** TAG_W;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   tag_cnt_t;

endpackage

// File: rtl/tag_fifo_if.sv
// rtl/tag_fifo_if.sv - dispatch/commit handshake bundle for the tag free-list
interface tag_fifo_if;
  import cobalt_pkg::*;

  logic     dispatch_tag_rd;
  tag_t     tagfifo_tag;
  logic     tagfifo_valid;
  logic     tagfifo_full;
  tag_cnt_t tagfifo_count;
  tag_t     rob_commit_tag;
  logic     rob_commit_valid;
  logic     tagfifo_err;

  modport slave (
    input  dispatch_tag_rd, rob_commit_tag, rob_commit_valid,
    output tagfifo_tag, tagfifo_valid, tagfifo_full, tagfifo_count, tagfifo_err
  );

  modport master (
    output dispatch_tag_rd, rob_commit_tag, rob_commit_valid,
    input  tagfifo_tag, tagfifo_valid, tagfifo_full, tagfifo_count, tagfifo_err
  );

endinterface

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - preloaded-full renaming tag free-list, show-ahead head
// Optional double-free / overflow / underflow checker: define TAG_FIFO_CHECK_EN.
module tag_fifo
  import cobalt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  tag_fifo_if.slave  tf
);

  tag_t     mem_q [NUM_TAGS];
  tag_cnt_t rd_ptr_q, rd_ptr_d;
  tag_cnt_t wr_ptr_q, wr_ptr_d;
  tag_t     head;
  logic     empty, full, pop_ok, push_ok;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty   = (rd_ptr_q == wr_ptr_q);
  assign full    = (rd_ptr_q[TAG_W-1:0] == wr_ptr_q[TAG_W-1:0]) &&
                   (rd_ptr_q[TAG_W] != wr_ptr_q[TAG_W]);
  assign pop_ok  = tf.dispatch_tag_rd && !empty;
  assign push_ok = tf.rob_commit_valid && !full;
  assign head    = mem_q[rd_ptr_q[TAG_W-1:0]];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + tag_cnt_t'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + tag_cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) mem_q[i] <= tag_t'(i);
      rd_ptr_q <= '0;
      wr_ptr_q <= tag_cnt_t'(NUM_TAGS);
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[TAG_W-1:0]] <= tf.rob_commit_tag;
    end
  end

  assign tf.tagfifo_tag   = head;
  assign tf.tagfifo_valid = !empty;
  assign tf.tagfifo_full  = full;
  assign tf.tagfifo_count = wr_ptr_q - rd_ptr_q;

`ifdef TAG_FIFO_CHECK_EN
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;

  // A tag is busy while held by dispatch; returning a non-busy tag is a double free.
  always_comb begin
    busy_d = busy_q;
    if (pop_ok)  busy_d[head] = 1'b1;
    if (push_ok) busy_d[tf.rob_commit_tag] = 1'b0;
    err_d = err_q
          | (tf.rob_commit_valid && (full || !busy_q[tf.rob_commit_tag]))
          | (tf.dispatch_tag_rd && empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign tf.tagfifo_err = err_q;
`else
  assign tf.tagfifo_err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_fifo.sv
// tb/tb_tag_fifo.sv - scoreboard bench for tag_fifo against a queue-based model
module tb_tag_fifo;
  import cobalt_pkg::*;

`ifdef TAG_FIFO_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  tag_fifo_if tf ();

  tag_fifo dut (.clk(clk), .reset(reset), .tf(tf));

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  tag_t mq[$];
  tag_t exp_q[$];
  tag_t held[$];
  bit   mout [NUM_TAGS];
  bit   merr;

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    held.delete();
    for (int i = 0; i < NUM_TAGS; i++) begin
      mq.push_back(tag_t'(i));
      mout[i] = 1'b0;
    end
    merr = 1'b0;
  endtask

  task automatic check_status();
    chk("count", int'(tf.tagfifo_count), mq.size());
    chk("valid", int'(tf.tagfifo_valid), int'(mq.size() != 0));
    chk("full", int'(tf.tagfifo_full), int'(mq.size() == NUM_TAGS));
    chk("err", int'(tf.tagfifo_err), int'(CHECK_EN && merr));
    if (mq.size() != 0) chk("head", int'(tf.tagfifo_tag), int'(mq[0]));
  endtask

  // One clock of stimulus; the model advances as the DUT will at the next edge.
  task automatic step(bit rd, bit pv, tag_t tg);
    bit   m_empty, m_full;
    tag_t t;
    @(negedge clk);
    check_status();
    tf.dispatch_tag_rd  = rd;
    tf.rob_commit_valid = pv;
    tf.rob_commit_tag   = tg;
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == NUM_TAGS);
    if (pv && (m_full || !mout[tg])) merr = 1'b1;
    if (rd && m_empty) merr = 1'b1;
    if (rd && !m_empty) begin
      t = mq.pop_front();
      exp_q.push_back(t);
      held.push_back(t);
      mout[t] = 1'b1;
    end
    if (pv && !m_full) begin
      mq.push_back(tg);
      mout[tg] = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic do_reset(int n, bit pv, tag_t tg);
    @(negedge clk);
    reset = 1'b1;
    tf.dispatch_tag_rd  = 1'b0;
    tf.rob_commit_valid = pv;
    tf.rob_commit_tag   = tg;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tf.rob_commit_valid = 1'b0;
    model_reset();
  endtask

  // Monitor: every accepted pop must deliver the next expected tag.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && tf.dispatch_tag_rd && tf.tagfifo_valid) begin
        if (exp_q.size() == 0) chk("sb_underflow", int'(tf.tagfifo_tag), -1);
        else chk("pop_tag", int'(tf.tagfifo_tag), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    tag_t t;
    reset = 1'b1;
    tf.dispatch_tag_rd  = 1'b0;
    tf.rob_commit_valid = 1'b0;
    tf.rob_commit_tag   = '0;
    model_reset();

    do_reset(5, 1'b0, '0);
    chk("rst_count", int'(tf.tagfifo_count), 64);
    chk("rst_tag", int'(tf.tagfifo_tag), 0);
    check_status();

    // Drain all 64 preloaded tags, then one pop past empty.
    for (int i = 0; i < NUM_TAGS; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("drain_count", int'(tf.tagfifo_count), 0);

    // Refill from empty with 5, 9, 2 and pop them back in order.
    step(1'b0, 1'b1, tag_t'(5));
    step(1'b0, 1'b1, tag_t'(9));
    step(1'b0, 1'b1, tag_t'(2));
    step(1'b0, 1'b0, '0);
    chk("three_count", int'(tf.tagfifo_count), 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Half-full steady state: pop and return a held tag every cycle.
    do_reset(1, 1'b0, '0);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 200; i++) begin
      idx = $urandom_range(0, held.size() - 1);
      t = held[idx];
      held.delete(idx);
      step(1'b1, 1'b1, t);
    end
    step(1'b0, 1'b0, '0);
    chk("steady_count", int'(tf.tagfifo_count), 32);

    // Randomised mix, mostly legal returns with occasional stray tags.
    do_reset(1, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      bit rd, pv;
      rd = ($urandom_range(0, 1) == 1);
      pv = ($urandom_range(0, 2) != 0);
      if (held.size() == 0 || $urandom_range(0, 15) == 0) begin
        t = tag_t'($urandom_range(0, NUM_TAGS - 1));
      end else begin
        idx = $urandom_range(0, held.size() - 1);
        t = held[idx];
        if (pv && mq.size() != NUM_TAGS) held.delete(idx);
      end
      step(rd, pv, t);
    end

    // Push while full is dropped; contents still 0..63.
    do_reset(1, 1'b0, '0);
    step(1'b0, 1'b1, tag_t'(7));
    step(1'b0, 1'b0, '0);
    chk("full_push_err", int'(tf.tagfifo_err), int'(CHECK_EN));
    for (int i = 0; i < NUM_TAGS; i++) step(1'b1, 1'b0, '0);

    // Reset during a push, then a double free of tag 0.
    do_reset(1, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    do_reset(1, 1'b1, tag_t'(3));
    chk("mid_rst_count", int'(tf.tagfifo_count), 64);
    chk("mid_rst_tag", int'(tf.tagfifo_tag), 0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, tag_t'(0));
    step(1'b0, 1'b0, '0);
    chk("first_free_err", int'(tf.tagfifo_err), 0);
    step(1'b1, 1'b1, tag_t'(0));
    step(1'b0, 1'b0, '0);
    chk("double_free_err", int'(tf.tagfifo_err), int'(CHECK_EN));

    @(negedge clk);
    #3;
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
